// File: rtl/sp_operand_c_loader_pkg.sv
// Shared definitions for the operand-C loader: dimension derivation helpers and FSM encoding.
package sp_operand_c_loader_pkg;

    function automatic int unsigned max_dim_f(input int unsigned bus_w, input int unsigned data_w);
        return bus_w / data_w;
    endfunction

    function automatic int unsigned elems_f(input int unsigned max_dim);
        return max_dim * max_dim;
    endfunction

    // A width of at least one bit keeps degenerate 1x1 configurations legal.
    function automatic int unsigned cnt_w_f(input int unsigned max_dim);
        return (max_dim > 1) ? $clog2(max_dim) : 1;
    endfunction

    function automatic int unsigned idx_w_f(input int unsigned elems);
        return (elems > 1) ? $clog2(elems) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sp_operand_c_loader_if.sv
// ScratchPad read port: the loader is master (strobe + address), the ScratchPad returns data.
interface sp_operand_c_loader_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned BUS_WIDTH  = 64
);
    logic                  sp_rd_en_o;
    logic [ADDR_WIDTH-1:0] sp_rd_addr_o;
    logic [BUS_WIDTH-1:0]  sp_rd_data_i;

    modport master (output sp_rd_en_o, output sp_rd_addr_o, input sp_rd_data_i);
    modport slave  (input sp_rd_en_o, input sp_rd_addr_o, output sp_rd_data_i);
endinterface

// File: rtl/sp_rc_counter.sv
// Row-major r/c counter with programmable limits; exposes current and next element index.
module sp_rc_counter #(
    parameter int unsigned MAX_DIM = 4,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned IDX_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             step_i,
    input  logic [CNT_W-1:0] rows_i,
    input  logic [CNT_W-1:0] cols_i,
    output logic             last_c,
    output logic [IDX_W-1:0] idx_c,
    output logic [IDX_W-1:0] nxt_idx_c
);

    logic [CNT_W-1:0] r_q, r_d, c_q, c_d;
    logic [CNT_W-1:0] r_s, c_s;
    logic             row_end;

    function automatic logic [IDX_W-1:0] idx_f(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] c);
        return IDX_W'(IDX_W'(r) * IDX_W'(MAX_DIM) + IDX_W'(c));
    endfunction

    always_comb begin
        row_end = (c_q == cols_i);
        c_s     = row_end ? '0 : c_q + CNT_W'(1);
        r_s     = row_end ? r_q + CNT_W'(1) : r_q;
        r_d     = r_q;
        c_d     = c_q;
        if (clr_i) begin
            r_d = '0;
            c_d = '0;
        end else if (step_i) begin
            r_d = r_s;
            c_d = c_s;
        end
    end

    assign last_c    = row_end && (r_q == rows_i);
    assign idx_c     = idx_f(r_q, c_q);
    assign nxt_idx_c = idx_f(r_s, c_s);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

endmodule

// File: rtl/sp_operand_c_loader.sv
// Reads matrix C element-by-element from the ScratchPad and packs it into the flat adder operand.
module sp_operand_c_loader
    import sp_operand_c_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned BUS_WIDTH    = 64,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned SP_NTARGETS  = 4,
    parameter int unsigned SP_BASE_ADDR = 0,
    localparam int unsigned MAX_DIM     = max_dim_f(BUS_WIDTH, DATA_WIDTH),
    localparam int unsigned ELEMS       = elems_f(MAX_DIM),
    localparam int unsigned CNT_W       = cnt_w_f(MAX_DIM),
    localparam int unsigned IDX_W       = idx_w_f(ELEMS),
    localparam int unsigned TGT_W       = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
    localparam int unsigned OP_W        = BUS_WIDTH * ELEMS
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [TGT_W-1:0]       target_i,
    input  logic [CNT_W-1:0]       rows_i,
    input  logic [CNT_W-1:0]       cols_i,
    sp_operand_c_loader_if.master  sp,
    output logic [OP_W-1:0]        operand_c_o,
    output logic                   busy_o,
    output logic                   done_o
);

    state_e                state_q, state_d;
    logic                  start_acc;
    logic                  last_c;
    logic [IDX_W-1:0]      idx_c, nxt_idx_c;

    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [TGT_W-1:0]      tgt_q, tgt_d;
    logic [CNT_W-1:0]      rows_q, rows_d, cols_q, cols_d;
    logic                  cap_v_q, cap_v_d;
    logic [IDX_W-1:0]      cap_idx_q, cap_idx_d;
    logic [OP_W-1:0]       op_q, op_d;

    function automatic logic [ADDR_WIDTH-1:0] addr_f(input logic [TGT_W-1:0] tgt, input logic [IDX_W-1:0] idx);
        int unsigned sum;
        sum = SP_BASE_ADDR + 32'(tgt) * ELEMS + 32'(idx);
        return ADDR_WIDTH'(sum);
    endfunction

    assign start_acc = (state_q == ST_IDLE) && start_i;

    sp_rc_counter #(
        .MAX_DIM (MAX_DIM),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) u_rc_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (start_acc),
        .step_i    ((state_q == ST_READ) && !last_c),
        .rows_i    (rows_q),
        .cols_i    (cols_q),
        .last_c    (last_c),
        .idx_c     (idx_c),
        .nxt_idx_c (nxt_idx_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_READ;
            ST_READ:  if (last_c)  state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        rd_en_d   = (state_d == ST_READ);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        addr_d    = addr_q;
        tgt_d     = tgt_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        cap_v_d   = (state_q == ST_READ);
        cap_idx_d = idx_c;
        op_d      = op_q;
        if (start_acc) begin
            tgt_d  = target_i;
            rows_d = rows_i;
            cols_d = cols_i;
            addr_d = addr_f(target_i, '0);
            op_d   = '0;
        end else if ((state_q == ST_READ) && !last_c) begin
            addr_d = addr_f(tgt_q, nxt_idx_c);
        end
        // Data returns one cycle after the strobe; slot chosen by the index captured with it.
        for (int unsigned l = 0; l < ELEMS; l++) begin
            if (cap_v_q && (cap_idx_q == IDX_W'(l)))
                op_d[l*BUS_WIDTH +: BUS_WIDTH] = sp.sp_rd_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tgt_q     <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            cap_v_q   <= 1'b0;
            cap_idx_q <= '0;
            op_q      <= '0;
        end else begin
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tgt_q     <= tgt_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            cap_v_q   <= cap_v_d;
            cap_idx_q <= cap_idx_d;
            op_q      <= op_d;
        end
    end

    assign sp.sp_rd_en_o   = rd_en_q;
    assign sp.sp_rd_addr_o = addr_q;
    assign operand_c_o     = op_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_sp_operand_c_loader.sv
// Bench for sp_operand_c_loader: two instances (base 0 and base 0xFFF8) against a cycle-level load model.
module tb_sp_operand_c_loader;

    localparam int BASE0 = 0;
    localparam int BASE1 = 32'h0000FFF8;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  target, rows, cols;
    logic [63:0] data_off;

    logic [1023:0] op0, op1;
    logic          busy0, busy1, done0, done1;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  chk_en = 1'b0;
    int  done_cnt0 = 0;
    int  done_cnt1 = 0;

    // load model: what was accepted, and when
    bit          have_load = 1'b0;
    bit          addr_zero = 1'b1;
    int          m_s = 0, m_tgt = 0, m_rows = 0, m_cols = 0;
    logic [63:0] m_off = '0;

    always #5 clk = ~clk;

    sp_operand_c_loader_if #(.ADDR_WIDTH(16), .BUS_WIDTH(64)) sp0 ();
    sp_operand_c_loader_if #(.ADDR_WIDTH(16), .BUS_WIDTH(64)) sp1 ();

    sp_operand_c_loader #(
        .DATA_WIDTH(16), .BUS_WIDTH(64), .ADDR_WIDTH(16), .SP_NTARGETS(4), .SP_BASE_ADDR(BASE0)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .target_i(target), .rows_i(rows), .cols_i(cols),
        .sp(sp0.master), .operand_c_o(op0), .busy_o(busy0), .done_o(done0)
    );

    sp_operand_c_loader #(
        .DATA_WIDTH(16), .BUS_WIDTH(64), .ADDR_WIDTH(16), .SP_NTARGETS(4), .SP_BASE_ADDR(BASE1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .target_i(target), .rows_i(rows), .cols_i(cols),
        .sp(sp1.master), .operand_c_o(op1), .busy_o(busy1), .done_o(done1)
    );

    // ScratchPad models: one-cycle read latency, garbage when not strobed
    always @(posedge clk) begin
        sp0.sp_rd_data_i <= sp0.sp_rd_en_o ? 64'(sp0.sp_rd_addr_o) + data_off : 64'hBAD0_BAD0_BAD0_BAD0;
        sp1.sp_rd_data_i <= sp1.sp_rd_en_o ? 64'(sp1.sp_rd_addr_o) + data_off : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // model acceptance: reset wins, start only taken once the previous load has fully retired
    always @(posedge clk) begin
        if (rst) begin
            have_load <= 1'b0;
            addr_zero <= 1'b1;
        end else if (start && (!have_load || cyc >= m_s + (m_rows + 1) * (m_cols + 1) + 3)) begin
            have_load <= 1'b1;
            addr_zero <= 1'b0;
            m_s       <= cyc;
            m_tgt     <= int'(target);
            m_rows    <= int'(rows);
            m_cols    <= int'(cols);
            m_off     <= data_off;
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] maddr(input int base, input int j);
        int r, c;
        r = j / (m_cols + 1);
        c = j % (m_cols + 1);
        return 16'(base + m_tgt * 16 + r * 4 + c);
    endfunction

    function automatic logic [63:0] el(input logic [1023:0] op, input int l);
        return op[l*64 +: 64];
    endfunction

    task automatic cmp(input int d, input int base, input logic en, input logic [15:0] addr,
                       input logic busy, input logic done, input logic [1023:0] op);
        int n, t, l;
        bit in_read;
        logic [63:0] e[16];
        t = cyc;
        n = (m_rows + 1) * (m_cols + 1);
        in_read = have_load && t >= m_s + 1 && t <= m_s + n;
        chk($sformatf("d%0d_rd_en", d), 64'(en), 64'(in_read));
        chk($sformatf("d%0d_busy", d), 64'(busy), 64'(have_load && t >= m_s + 1 && t <= m_s + n + 2));
        chk($sformatf("d%0d_done", d), 64'(done), 64'(have_load && t == m_s + n + 2));
        if (in_read) chk($sformatf("d%0d_addr", d), 64'(addr), 64'(maddr(base, t - m_s - 1)));
        else if (addr_zero) chk($sformatf("d%0d_addr_rst", d), 64'(addr), 64'd0);
        for (int i = 0; i < 16; i++) e[i] = '0;
        if (have_load) begin
            for (int j = 0; j < n; j++) begin
                if (t >= m_s + 3 + j) begin
                    l = (j / (m_cols + 1)) * 4 + j % (m_cols + 1);
                    e[l] = 64'(maddr(base, j)) + m_off;
                end
            end
        end
        for (int i = 0; i < 16; i++) chk($sformatf("d%0d_elem%0d", d, i), el(op, i), e[i]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, BASE0, sp0.sp_rd_en_o, sp0.sp_rd_addr_o, busy0, done0, op0);
            cmp(1, BASE1, sp1.sp_rd_en_o, sp1.sp_rd_addr_o, busy1, done1, op1);
            done_cnt0 += int'(done0);
            done_cnt1 += int'(done1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic launch(input logic [1:0] tg, input logic [1:0] r, input logic [1:0] c, output int s);
        s = cyc;
        start = 1'b1; target = tg; rows = r; cols = c;
        step();
        start = 1'b0;
    endtask

    initial begin
        int s, dc;
        rst = 1'b1; start = 1'b0; target = '0; rows = '0; cols = '0; data_off = '0;
        repeat (2) step();
        chk_en = 1'b1;
        chk("rst_en", 64'(sp0.sp_rd_en_o), 64'd0);
        chk("rst_addr", 64'(sp0.sp_rd_addr_o), 64'd0);
        chk("rst_op", 64'(|op0), 64'd0);
        rst = 1'b0;
        step();

        // 4x4, target 2, data = address
        launch(2'd2, 2'd3, 2'd3, s);
        chk("t1_addr_first", 64'(sp0.sp_rd_addr_o), 64'd32);
        step_to(s + 16); chk("t1_addr_last", 64'(sp0.sp_rd_addr_o), 64'd47);
        step_to(s + 17); chk("t1_en_drain", 64'(sp0.sp_rd_en_o), 64'd0);
        step_to(s + 18); chk("t1_done", 64'(done0), 64'd1);
        step_to(s + 19);
        for (int l = 0; l < 16; l++) chk($sformatf("t1_elem%0d", l), el(op0, l), 64'(32 + l));
        chk("t1_d1_elem0_wrap", el(op1, 0), 64'h18);

        // 2x3, target 0, data = address + 0x100
        data_off = 64'h100;
        launch(2'd0, 2'd1, 2'd2, s);
        step_to(s + 4); chk("t2_addr_row1", 64'(sp0.sp_rd_addr_o), 64'd4);
        step_to(s + 6); chk("t2_addr_last", 64'(sp0.sp_rd_addr_o), 64'd6);
        step_to(s + 8); chk("t2_done", 64'(done0), 64'd1);
        step_to(s + 9);
        chk("t2_elem2", el(op0, 2), 64'h102);
        chk("t2_elem3", el(op0, 3), 64'h0);
        chk("t2_elem4", el(op0, 4), 64'h104);
        chk("t2_elem6", el(op0, 6), 64'h106);
        chk("t2_elem7", el(op0, 7), 64'h0);
        chk("t2_elem15", el(op0, 15), 64'h0);
        data_off = '0;

        // 1x1, target 3
        launch(2'd3, 2'd0, 2'd0, s);
        chk("t3_addr", 64'(sp0.sp_rd_addr_o), 64'd48);
        step_to(s + 2); chk("t3_busy2", 64'(busy0), 64'd1);
        step_to(s + 3); chk("t3_done", 64'(done0), 64'd1);
        step_to(s + 4); chk("t3_busy4", 64'(busy0), 64'd0);
        chk("t3_elem0", el(op0, 0), 64'd48);

        // start held through a load while target/dims change
        dc = done_cnt0;
        s = cyc;
        start = 1'b1; target = 2'd3; rows = 2'd3; cols = 2'd3;
        step();
        target = 2'd1; rows = 2'd0; cols = 2'd0;
        chk("t4_addr_first", 64'(sp0.sp_rd_addr_o), 64'd48);
        step_to(s + 16); chk("t4_addr_last", 64'(sp0.sp_rd_addr_o), 64'd63);
        step_to(s + 19); chk("t4_idle_gap", 64'(busy0), 64'd0);
        step_to(s + 20);
        start = 1'b0;
        chk("t4_second_addr", 64'(sp0.sp_rd_addr_o), 64'd16);
        step_to(s + 23);
        chk("t4_done_count", 64'(done_cnt0 - dc), 64'd2);
        chk("t4_elem0", el(op0, 0), 64'd16);
        chk("t4_elem1", el(op0, 1), 64'd0);

        // reset with simultaneous start mid-load
        launch(2'd2, 2'd3, 2'd3, s);
        step_to(s + 5);
        rst = 1'b1; start = 1'b1; target = 2'd1;
        step();
        chk("t5_en", 64'(sp0.sp_rd_en_o), 64'd0);
        chk("t5_busy", 64'(busy0), 64'd0);
        chk("t5_op", 64'(|op0), 64'd0);
        chk("t5_d1_op", 64'(|op1), 64'd0);
        rst = 1'b0; start = 1'b0;
        dc = done_cnt0;
        repeat (20) step();
        chk("t5_no_done", 64'(done_cnt0 - dc), 64'd0);
        launch(2'd1, 2'd1, 2'd1, s);
        chk("t5_restart_addr", 64'(sp0.sp_rd_addr_o), 64'd16);
        step_to(s + 6); chk("t5_restart_done", 64'(done0), 64'd1);
        step_to(s + 7); chk("t5_elem5", el(op0, 5), 64'd21);

        // address wrap on the 0xFFF8-based instance
        launch(2'd0, 2'd3, 2'd3, s);
        chk("t6_addr_first", 64'(sp1.sp_rd_addr_o), 64'hFFF8);
        step_to(s + 9);  chk("t6_addr_wrap", 64'(sp1.sp_rd_addr_o), 64'h0000);
        step_to(s + 16); chk("t6_addr_last", 64'(sp1.sp_rd_addr_o), 64'h0007);
        step_to(s + 19);
        chk("t6_elem7", el(op1, 7), 64'hFFFF);
        chk("t6_elem9", el(op1, 9), 64'h1);
        chk("t6_elem15", el(op1, 15), 64'h7);
        chk("t6_done_count", 64'(done_cnt1 - done_cnt0), 64'd0);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
